// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions.
//   FB_WIDTH/FB_HEIGHT : frame buffer geometry in pixels
//   ADDR_W/DATA_W      : video RAM address and pixel widths
//   rgb565_t           : pixel layout, r[15:11] g[10:5] b[4:0]
//   fill_state_t       : rectangle fill FSM states
//   row_base()         : y*FB_WIDTH as a shift-add, also used by scan-out
package fb_pkg;

  localparam int FB_WIDTH  = 400;
  localparam int FB_HEIGHT = 240;
  localparam int ADDR_W    = 17;
  localparam int DATA_W    = 16;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_t;

  // y*400 = y*256 + y*128 + y*16; no multiplier needed
  function automatic logic [ADDR_W-1:0] row_base(input logic [7:0] y);
    logic [ADDR_W-1:0] ye;
    ye = {{(ADDR_W-8){1'b0}}, y};
    return (ye << 8) + (ye << 7) + (ye << 4);
  endfunction

endpackage

// File: rtl/fb_rect_clip.sv
// Combinational clipping of a draw command against the frame buffer.
//   x, y      : rectangle origin (column, row)
//   w, h      : rectangle size
//   x1, y1    : exclusive clipped right/bottom bounds
//   rowBase   : video RAM address of column 0 on row y
//   empty     : command covers no visible pixel
module fb_rect_clip
  import fb_pkg::*;
(
  input  logic [8:0]        x,
  input  logic [7:0]        y,
  input  logic [8:0]        w,
  input  logic [7:0]        h,
  output logic [9:0]        x1,
  output logic [8:0]        y1,
  output logic [ADDR_W-1:0] rowBase,
  output logic              empty
);

  logic [9:0] xEnd;
  logic [8:0] yEnd;

  // One extra bit so x+w and y+h cannot wrap before the clamp
  assign xEnd = {1'b0, x} + {1'b0, w};
  assign yEnd = {1'b0, y} + {1'b0, h};

  assign x1 = (xEnd > 10'(FB_WIDTH))  ? 10'(FB_WIDTH) : xEnd;
  assign y1 = (yEnd > 9'(FB_HEIGHT))  ? 9'(FB_HEIGHT) : yEnd;

  assign rowBase = row_base(y);

  assign empty = (w == 9'd0) || (h == 8'd0) ||
                 (x >= 9'(FB_WIDTH)) || (y >= 8'(FB_HEIGHT));

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: accepts a draw command, clips it to the frame
// buffer and writes one pixel per clock into video RAM.
//   clock, reset       : data clock, synchronous active-high reset
//   cmdValid/cmdReady  : command handshake (ready only while idle)
//   cmdX/Y/W/H/Color   : rectangle origin, size and RGB565 fill value
//   wrAddr/wrData/wrEn : video RAM write port
//   busy               : command in progress, accept through done
//   done               : one-cycle completion pulse
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for a command, cmdReady high
// ST_SETUP | clip bounds and row base registered, first pixel queued
// ST_DRAW  | a pixel write is on the port this cycle
// ST_DONE  | done pulse, back to idle next
module fb_rect_fill
  import fb_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              cmdValid,
  output logic              cmdReady,
  input  logic [8:0]        cmdX,
  input  logic [7:0]        cmdY,
  input  logic [8:0]        cmdW,
  input  logic [7:0]        cmdH,
  input  logic [DATA_W-1:0] cmdColor,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData,
  output logic              wrEn,
  output logic              busy,
  output logic              done
);

  fill_state_t state, stateNxt;

  logic [8:0]        xOrg, xOrgNxt;
  logic [7:0]        yOrg, yOrgNxt;
  logic [8:0]        wLat, wLatNxt;
  logic [7:0]        hLat, hLatNxt;
  rgb565_t           color, colorNxt;
  logic [9:0]        xEnd, xEndNxt;
  logic [8:0]        yEnd, yEndNxt;
  logic [ADDR_W-1:0] rowBase, rowBaseNxt;
  logic [8:0]        col, colNxt;
  logic [7:0]        row, rowNxt;
  logic [ADDR_W-1:0] wrAddrNxt;
  logic [DATA_W-1:0] wrDataNxt;
  logic              wrEnNxt, busyNxt, doneNxt;

  logic [9:0]        clipX1;
  logic [8:0]        clipY1;
  logic [ADDR_W-1:0] clipRowBase;
  logic              clipEmpty;
  logic              lastCol, lastRow;
  logic [ADDR_W-1:0] nextRowBase;

  fb_rect_clip u_clip (
    .x       (xOrg),
    .y       (yOrg),
    .w       (wLat),
    .h       (hLat),
    .x1      (clipX1),
    .y1      (clipY1),
    .rowBase (clipRowBase),
    .empty   (clipEmpty)
  );

  assign cmdReady    = (state == ST_IDLE);
  assign lastCol     = ({1'b0, col} == (xEnd - 10'd1));
  assign lastRow     = ({1'b0, row} == (yEnd - 9'd1));
  assign nextRowBase = rowBase + ADDR_W'(FB_WIDTH);

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= stateNxt;
  end

  always_comb begin
    stateNxt   = state;
    xOrgNxt    = xOrg;
    yOrgNxt    = yOrg;
    wLatNxt    = wLat;
    hLatNxt    = hLat;
    colorNxt   = color;
    xEndNxt    = xEnd;
    yEndNxt    = yEnd;
    rowBaseNxt = rowBase;
    colNxt     = col;
    rowNxt     = row;
    wrAddrNxt  = wrAddr;
    wrDataNxt  = wrData;
    wrEnNxt    = 1'b0;
    busyNxt    = busy;
    doneNxt    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cmdValid) begin
          stateNxt = ST_SETUP;
          xOrgNxt  = cmdX;
          yOrgNxt  = cmdY;
          wLatNxt  = cmdW;
          hLatNxt  = cmdH;
          colorNxt = rgb565_t'(cmdColor);
          busyNxt  = 1'b1;
        end
      end
      ST_SETUP: begin
        xEndNxt    = clipX1;
        yEndNxt    = clipY1;
        rowBaseNxt = clipRowBase;
        colNxt     = xOrg;
        rowNxt     = yOrg;
        wrDataNxt  = color;
        if (clipEmpty) begin
          stateNxt = ST_DONE;
          doneNxt  = 1'b1;
        end else begin
          // first pixel goes out on the edge that leaves SETUP
          stateNxt  = ST_DRAW;
          wrEnNxt   = 1'b1;
          wrAddrNxt = clipRowBase + {{(ADDR_W-9){1'b0}}, xOrg};
        end
      end
      ST_DRAW: begin
        // col/row track the pixel currently on the write port
        if (lastCol && lastRow) begin
          stateNxt = ST_DONE;
          doneNxt  = 1'b1;
        end else if (lastCol) begin
          wrEnNxt    = 1'b1;
          colNxt     = xOrg;
          rowNxt     = row + 8'd1;
          rowBaseNxt = nextRowBase;
          wrAddrNxt  = nextRowBase + {{(ADDR_W-9){1'b0}}, xOrg};
        end else begin
          wrEnNxt   = 1'b1;
          colNxt    = col + 9'd1;
          wrAddrNxt = wrAddr + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        stateNxt = ST_IDLE;
        busyNxt  = 1'b0;
      end
      default: stateNxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      xOrg    <= '0;
      yOrg    <= '0;
      wLat    <= '0;
      hLat    <= '0;
      color   <= '0;
      xEnd    <= '0;
      yEnd    <= '0;
      rowBase <= '0;
      col     <= '0;
      row     <= '0;
      wrAddr  <= '0;
      wrData  <= '0;
      wrEn    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      xOrg    <= xOrgNxt;
      yOrg    <= yOrgNxt;
      wLat    <= wLatNxt;
      hLat    <= hLatNxt;
      color   <= colorNxt;
      xEnd    <= xEndNxt;
      yEnd    <= yEndNxt;
      rowBase <= rowBaseNxt;
      col     <= colNxt;
      row     <= rowNxt;
      wrAddr  <= wrAddrNxt;
      wrData  <= wrDataNxt;
      wrEn    <= wrEnNxt;
      busy    <= busyNxt;
      done    <= doneNxt;
    end
  end

endmodule
